// File: rtl/oifs_tx_arbiter.sv
// oifs_tx_arbiter: shares the OIFS tx link between N_CH word sources, round-robin, in bursts of up to BURST words.
// Build option: define OIFS_TX_ARB_PRIO_EN to give requester 0 strict priority at every arbitration.
module oifs_tx_arbiter #(
  parameter int  N_CH   = 2,
  parameter int  DATA_W = 8,
  parameter int  BURST  = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_arst,
  input  logic [N_CH-1:0]          i_valid,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  output logic [N_CH-1:0]          o_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_channel,
  input  logic                     i_ready
);

  // Handshake: a word moves when valid and ready are both high at a rising i_clk edge;
  // a source keeps valid/data steady until accepted, and o_valid/o_data/o_channel hold until i_ready.

  localparam int              CNT_W    = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_channel_q, out_channel_d;

  logic              hi_found, lo_found;
  logic [CH_W-1:0]   hi_sel, lo_sel, rr_sel, arb_sel;
  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              in_grant, ready_g, accept;

  // Cyclic search from last_grant+1: prefer the lowest index above last_grant, else wrap.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_valid[k]) begin
        if (k > int'(last_grant_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_sel   = CH_W'(k);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_sel   = CH_W'(k);
        end
      end
    end
    rr_sel = hi_found ? hi_sel : lo_sel;
  end

`ifdef OIFS_TX_ARB_PRIO_EN
  // With requester 0 idle the round-robin search naturally skips it.
  assign arb_sel = i_valid[0] ? '0 : rr_sel;
`else
  assign arb_sel = rr_sel;
`endif

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_q == CH_W'(k)) begin
        g_valid = i_valid[k];
        g_data  = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign in_grant = (state_q == GRANT);
  assign ready_g  = ~out_valid_q | i_ready;
  assign accept   = in_grant & g_valid & ready_g;

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_ready[k] = in_grant & (grant_q == CH_W'(k)) & ready_g;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    burst_cnt_d   = burst_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;

    case (state_q)
      IDLE: begin
        if (|i_valid) begin
          grant_d     = arb_sel;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!g_valid) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q == LAST_CNT) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = g_data;
      out_channel_d = grant_q;
    end else if (out_valid_q && i_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= LAST_CH;
      burst_cnt_q   <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      burst_cnt_q   <= burst_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign o_valid   = out_valid_q;
  assign o_data    = out_data_q;
  assign o_channel = out_channel_q;

endmodule

// File: tb/tb_oifs_tx_arbiter.sv
// Bench for oifs_tx_arbiter: two instances (2ch/BURST=4 and 3ch/BURST=1), directed vectors, queue scoreboard.
module tb_oifs_tx_arbiter;
  localparam int DW = 8;
  localparam int WA = 1 + DW;
  localparam int WB = 2 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [1:0]      a_valid;
  logic [2*DW-1:0] a_data;
  logic [1:0]      a_ready;
  logic            a_ovalid;
  logic [DW-1:0]   a_odata;
  logic            a_och;
  logic            a_iready;

  logic [2:0]      b_valid;
  logic [3*DW-1:0] b_data;
  logic [2:0]      b_ready;
  logic            b_ovalid;
  logic [DW-1:0]   b_odata;
  logic [1:0]      b_och;
  logic            b_iready;

  oifs_tx_arbiter #(.N_CH(2), .DATA_W(DW), .BURST(4)) dut_a (
    .i_clk(clk), .i_arst(arst), .i_valid(a_valid), .i_data(a_data), .o_ready(a_ready),
    .o_valid(a_ovalid), .o_data(a_odata), .o_channel(a_och), .i_ready(a_iready)
  );

  oifs_tx_arbiter #(.N_CH(3), .DATA_W(DW), .BURST(1)) dut_b (
    .i_clk(clk), .i_arst(arst), .i_valid(b_valid), .i_data(b_data), .o_ready(b_ready),
    .o_valid(b_ovalid), .o_data(b_odata), .o_channel(b_och), .i_ready(b_iready)
  );

  int            rem_a[2];
  logic [DW-1:0] dat_a[2];
  int            rem_b[3];
  logic [DW-1:0] dat_b[3];

  logic [WA-1:0] exp_qa[$];
  logic [WB-1:0] exp_qb[$];
  int total = 0;
  int bad   = 0;

  logic          s_va, s_ca, s_vb;
  logic [DW-1:0] s_da;
  logic [1:0]    s_ra;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!arst && a_ovalid && a_iready) begin
      if (exp_qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_word: got ch%0d 0x%0h expected none", a_och, a_odata);
      end else begin
        check("a_word", 32'({a_och, a_odata}), 32'(exp_qa.pop_front()));
      end
    end
    if (!arst && b_ovalid && b_iready) begin
      if (exp_qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_word: got ch%0d 0x%0h expected none", b_och, b_odata);
      end else begin
        check("b_word", 32'({b_och, b_odata}), 32'(exp_qb.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic apply_inputs();
    for (int k = 0; k < 2; k++) begin
      a_valid[k]          = (rem_a[k] > 0);
      a_data[k*DW +: DW]  = dat_a[k];
    end
    for (int k = 0; k < 3; k++) begin
      b_valid[k]          = (rem_b[k] > 0);
      b_data[k*DW +: DW]  = dat_b[k];
    end
  endtask

  task automatic clear_sources();
    for (int k = 0; k < 2; k++) rem_a[k] = 0;
    for (int k = 0; k < 3; k++) rem_b[k] = 0;
    apply_inputs();
  endtask

  task automatic push_a(input logic ch, input logic [DW-1:0] d);
    exp_qa.push_back({ch, d});
  endtask

  task automatic push_b(input logic [1:0] ch, input logic [DW-1:0] d);
    exp_qb.push_back({ch, d});
  endtask

  // One clock: sample outputs at the falling edge, then advance sources that were accepted.
  task automatic step(output logic va, output logic [DW-1:0] da, output logic ca,
                      output logic [1:0] ra, output logic vb);
    logic [1:0] fa;
    logic [2:0] fb;
    @(negedge clk);
    va = a_ovalid;
    da = a_odata;
    ca = a_och;
    ra = a_ready;
    vb = b_ovalid;
    fa = a_valid & a_ready;
    fb = b_valid & b_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) if (fa[k]) begin rem_a[k]--; dat_a[k]++; end
    for (int k = 0; k < 3; k++) if (fb[k]) begin rem_b[k]--; dat_b[k]++; end
    apply_inputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(s_va, s_da, s_ca, s_ra, s_vb);
  endtask

  logic [15:0] pat1;
  logic [9:0]  pat3;
  logic [12:0] pat5;

  initial begin
    arst     = 1'b1;
    a_iready = 1'b1;
    b_iready = 1'b1;
    for (int k = 0; k < 2; k++) dat_a[k] = '0;
    for (int k = 0; k < 3; k++) dat_b[k] = '0;
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", 32'(a_ovalid), 0);
    check("rst_a_data", 32'(a_odata), 0);
    check("rst_a_channel", 32'(a_och), 0);
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_b_valid", 32'(b_ovalid), 0);
    arst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: ch0/ch1 continuously valid, alternating bursts of 4
    rem_a[0] = 100; dat_a[0] = 8'h10;
    rem_a[1] = 100; dat_a[1] = 8'h20;
    apply_inputs();
`ifdef OIFS_TX_ARB_PRIO_EN
    for (int i = 0; i < 12; i++) push_a(1'b0, 8'(8'h10 + i));
`else
    for (int i = 0; i < 4; i++) push_a(1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) push_a(1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) push_a(1'b0, 8'(8'h14 + i));
`endif
    pat1 = 16'b1111_0111_1011_1100;
    for (int n = 0; n < 16; n++) begin
      step(s_va, s_da, s_ca, s_ra, s_vb);
      check($sformatf("t1_valid_%0d", n), 32'(s_va), 32'(pat1[n]));
    end
    clear_sources();
    idle_steps(4);

    // Test 2: ch1 alone, downstream stalled for 5 cycles after first accept
    rem_a[1] = 2; dat_a[1] = 8'hA5;
    apply_inputs();
    push_a(1'b1, 8'hA5);
    push_a(1'b1, 8'hA6);
    idle_steps(2);
    a_iready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step(s_va, s_da, s_ca, s_ra, s_vb);
      check("t2_stall_valid", 32'(s_va), 1);
      check("t2_stall_data", 32'(s_da), 32'h A5);
      check("t2_stall_channel", 32'(s_ca), 1);
      check("t2_stall_ready", 32'(s_ra), 0);
    end
    a_iready = 1'b1;
    idle_steps(6);

    // Test 3: ch0 drops valid after 2 words, ch1 then granted after one idle cycle
    rem_a[0] = 2; dat_a[0] = 8'h30;
    rem_a[1] = 3; dat_a[1] = 8'h40;
    apply_inputs();
    push_a(1'b0, 8'h30);
    push_a(1'b0, 8'h31);
    push_a(1'b1, 8'h40);
    push_a(1'b1, 8'h41);
    push_a(1'b1, 8'h42);
    pat3 = 10'b01_1100_1100;
    for (int n = 0; n < 10; n++) begin
      step(s_va, s_da, s_ca, s_ra, s_vb);
      check($sformatf("t3_valid_%0d", n), 32'(s_va), 32'(pat3[n]));
    end
    idle_steps(3);

    // Test 4: reset during a ch1 burst; afterwards ch0 must win first
    rem_a[0] = 1; dat_a[0] = 8'h5F;
    apply_inputs();
    push_a(1'b0, 8'h5F);
    idle_steps(4);
    rem_a[1] = 10; dat_a[1] = 8'h50;
    apply_inputs();
    push_a(1'b1, 8'h50);
    idle_steps(3);
    arst = 1'b1;
    #1;
    check("t4_arst_valid", 32'(a_ovalid), 0);
    check("t4_arst_data", 32'(a_odata), 0);
    check("t4_arst_channel", 32'(a_och), 0);
    check("t4_arst_ready", 32'(a_ready), 0);
    clear_sources();
    idle_steps(2);
    arst = 1'b0;
    rem_a[0] = 1; dat_a[0] = 8'h61;
    rem_a[1] = 1; dat_a[1] = 8'h71;
    apply_inputs();
    push_a(1'b0, 8'h61);
    push_a(1'b1, 8'h71);
    idle_steps(8);

    // Test 5: BURST=1, three channels all valid
    rem_b[0] = 2; dat_b[0] = 8'h80;
    rem_b[1] = 2; dat_b[1] = 8'h90;
    rem_b[2] = 2; dat_b[2] = 8'hA0;
    apply_inputs();
`ifdef OIFS_TX_ARB_PRIO_EN
    push_b(2'd0, 8'h80);
    push_b(2'd0, 8'h81);
    push_b(2'd1, 8'h90);
    push_b(2'd2, 8'hA0);
    push_b(2'd1, 8'h91);
    push_b(2'd2, 8'hA1);
`else
    push_b(2'd0, 8'h80);
    push_b(2'd1, 8'h90);
    push_b(2'd2, 8'hA0);
    push_b(2'd0, 8'h81);
    push_b(2'd1, 8'h91);
    push_b(2'd2, 8'hA1);
`endif
    pat5 = 13'b1_0101_0101_0100;
    for (int n = 0; n < 13; n++) begin
      step(s_va, s_da, s_ca, s_ra, s_vb);
      check($sformatf("t5_valid_%0d", n), 32'(s_vb), 32'(pat5[n]));
    end
    idle_steps(5);

    // final report
    check("a_queue_empty", 32'(exp_qa.size()), 0);
    check("b_queue_empty", 32'(exp_qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oifs_tx_arbiter.md
Name: oifs_tx_arbiter

Overview:
- Shares the single OIFS transmit link between N_CH data sources.
- Each source presents a valid/ready word stream. The arbiter grants sources round-robin in bursts of up to BURST words.
- It forwards the granted words, tagged with a channel number, through a registered valid/ready output stage to the link serializer.
- It sits between the per-channel pattern/data generators and the tx framer; the framer consumes o_data and o_channel.

Parameters:
- N_CH, 2, number of requesters (2..8).
- DATA_W, 8, data word width.
- BURST, 4, maximum words accepted per grant before re-arbitration (1..255).
- CH_W is a derived localparam, max(1, clog2(N_CH)); it is not overridable.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  reset
- i_valid  in  N_CH  per-requester word valid
- i_data  in  N_CH*DATA_W  per-requester word; requester k occupies bits [k*DATA_W +: DATA_W]
- o_ready  out  N_CH  per-requester accept
- o_valid  out  1  output word valid
- o_data  out  DATA_W  output word
- o_channel  out  CH_W  source index of o_data
- i_ready  in  1  downstream accept

Interface (already decided):
- Reset is i_arst: asynchronous, active-high. Clock is i_clk.
- All state is cleared asynchronously by i_arst.
- Transfers occur on valid&ready at the rising edge of i_clk.

Behaviour:
- Reset values:
  - Outputs: o_valid=0, o_data=0, o_channel=0, o_ready=0.
  - Internal: state=IDLE, grant=0, burst_cnt=0, last_grant=N_CH-1, so channel 0 wins first.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any i_valid is high, select the first requester with i_valid high, searching cyclically from last_grant+1.
  - Register the selection as grant, clear burst_cnt, go to GRANT.
  - If no i_valid is high, stay in IDLE. Each arbitration costs exactly one bubble cycle.
- GRANT:
  - o_ready[grant] = ~o_valid | i_ready. All other o_ready bits are 0. o_ready is combinational from registered state and i_ready.
  - Accept (i_valid[grant] & o_ready[grant]): load the output register with o_data=i_data[grant], o_channel=grant, o_valid=1, and increment burst_cnt.
  - If an accept occurs with burst_cnt==BURST-1, set last_grant=grant and go to IDLE.
  - If i_valid[grant]==0 in a GRANT cycle, set last_grant=grant and go to IDLE. No word is accepted that cycle.
  - Downstream stall (o_valid & ~i_ready): hold o_data, o_valid and o_channel stable; o_ready stays 0; state and burst_cnt hold.
- Output register:
  - When o_valid & i_ready with no new accept in the same cycle, clear o_valid to 0.
  - o_data and o_channel retain their last values when o_valid=0.
- Latency: a word accepted in cycle t appears on the outputs in cycle t+1.
- Throughput: with i_ready held high, one word per cycle within a burst, plus one idle cycle per arbitration.
- Boundary conditions:
  - A requester dropping i_valid mid-burst forfeits the remainder of its burst.
  - A non-granted requester raising i_valid waits until re-arbitration.
  - BURST=1 means every word re-arbitrates.
  - i_arst mid-burst discards any held output word and returns to the reset state.
  - burst_cnt width is clog2(BURST+1). burst_cnt never wraps because the state always exits at BURST-1.
  - An index N_CH..2^CH_W-1 is never granted.

Optional Feature:
- Macro: OIFS_TX_ARB_PRIO_EN.
- Defined: requester 0 has strict priority at every arbitration. In IDLE, if i_valid[0]==1, grant=0 regardless of last_grant; otherwise round-robin applies among requesters 1..N_CH-1 as above. Bursts are never preempted mid-burst; priority is only evaluated in IDLE.
- Undefined: pure round-robin across all requesters as specified in Behaviour.

Test Plan:
- Reset, then ch0 and ch1 both valid continuously with data 0x10.. and 0x20.., i_ready=1, BURST=4 -> output sequence 0x10,0x11,0x12,0x13 on channel 0, one bubble, 0x20..0x23 on channel 1, bubble, 0x14.. on channel 0.
- ch1 only valid, sending 0xA5, i_ready held 0 for 5 cycles after the first accept -> o_valid=1, o_data=0xA5, o_channel=1 stable for all 5 cycles; o_ready[1]=0; no second word lost or duplicated.
- ch0 granted, drops i_valid after 2 words while ch1 is valid -> ch0 burst ends after 2 words, IDLE for one cycle, then ch1 is granted.
- Assert i_arst during a burst with o_valid=1 -> all outputs 0 immediately; after release, channel 0 wins the first arbitration.
- BURST=1 with N_CH=3 and all channels valid -> o_channel sequence 0,1,2,0,1,2 with a bubble between each word.
- With OIFS_TX_ARB_PRIO_EN defined and ch0/ch1 continuously valid -> only channel 0 words are observed after each burst; without the macro, channels alternate.
